// File: rtl/up_mem_arbiter_if.sv
// up_mem_arbiter_if: requester-side and memory-side signals of the shared
// up_memory arbiter, bundled so the arbiter and its environment share one
// definition. The slave modport is the arbiter; the master modport is the
// environment (both requesters plus up_memory).
interface up_mem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
) ();
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata1;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_in;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_out;

    logic          busy;
    logic          grant;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_out,
        output ack0, rdata0, ack1, rdata1,
        output mem_addr, mem_in, mem_we, mem_re,
        output busy, grant
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_out,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_addr, mem_in, mem_we, mem_re,
        input  busy, grant
    );
endinterface

// File: rtl/up_mem_arbiter.sv
// up_mem_arbiter: two-port arbiter and access sequencer for the shared
// up_memory. Each access runs capture -> strobe -> read-wait -> acknowledge.
// Optional macro UP_MEM_ARB_RR_EN: round-robin arbitration between the two
// ports; when undefined, port 0 has fixed priority and no last-grant state
// exists.
//
// state | meaning
// IDLE  | no access; arbitrate and latch the winner's request
// ACC   | one-cycle memory strobe (mem_we or mem_re)
// WAIT  | read latency wait, counter runs 1..RD_LAT
// ACK   | one-cycle ack to the granted port
module up_mem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    up_mem_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t        state_q;
    logic [1:0]    cnt_q;
    logic          op_q;
    logic          grant_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          mem_we_q;
    logic          mem_re_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_in_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          any_req;
    logic          win_d;

    assign any_req = bus.req0 | bus.req1;

`ifdef UP_MEM_ARB_RR_EN
    logic last_q;

    // Winner selection: on contention the port not granted last wins.
    always_comb begin
        win_d = bus.req1;
        if (bus.req0 && bus.req1) begin
            win_d = ~last_q;
        end
    end

    // Last-grant tracking; reset to 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            last_q <= win_d;
        end
    end
`else
    // Winner selection: fixed priority, port 0 wins whenever it requests.
    always_comb begin
        win_d = ~bus.req0;
    end
`endif

    // Access sequencer with registered strobes, acks and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            op_q       <= 1'b0;
            grant_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_in_q   <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q    <= win_d;
                        mem_addr_q <= win_d ? bus.addr1  : bus.addr0;
                        mem_in_q   <= win_d ? bus.wdata1 : bus.wdata0;
                        op_q       <= win_d ? bus.we1    : bus.we0;
                        mem_we_q   <= win_d ? bus.we1    : bus.we0;
                        mem_re_q   <= win_d ? ~bus.we1   : ~bus.we0;
                        state_q    <= ACC;
                    end
                end
                ACC: begin
                    if (op_q || RD_LAT == 0) begin
                        // Zero-latency reads sample mem_out during the strobe itself.
                        if (!op_q) begin
                            if (grant_q) rdata1_q <= bus.mem_out;
                            else         rdata0_q <= bus.mem_out;
                        end
                        ack0_q  <= ~grant_q;
                        ack1_q  <= grant_q;
                        state_q <= ACK;
                    end else begin
                        cnt_q   <= 2'd1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == LAT) begin
                        if (grant_q) rdata1_q <= bus.mem_out;
                        else         rdata0_q <= bus.mem_out;
                        ack0_q  <= ~grant_q;
                        ack1_q  <= grant_q;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    cnt_q   <= 2'd0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_in   = mem_in_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_re   = mem_re_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.grant    = grant_q;
endmodule

// File: tb/tb_up_mem_arbiter.sv
// Bench for up_mem_arbiter. Expected acks are queued when an access is
// launched and consumed by a negedge monitor when the DUT acknowledges.
module tb_up_mem_arbiter;
    parameter int RD_LAT = 1;

    typedef struct {
        int         port;
        bit         we;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    up_mem_arbiter_if #(.AW(8), .DW(8)) bus ();

    up_mem_arbiter #(.AW(8), .DW(8), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] pipe    [0:3];

    // Memory model: synchronous write, read data appears RD_LAT cycles after
    // the strobe cycle and is poisoned otherwise.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_in;
        pipe[1] <= bus.mem_re ? mem[bus.mem_addr] : 8'hEE;
        pipe[2] <= pipe[1];
        pipe[3] <= pipe[2];
    end
    assign bus.mem_out = (RD_LAT == 0) ? (bus.mem_re ? mem[bus.mem_addr] : 8'hEE)
                                       : pipe[RD_LAT];

    // Ack monitor: exclusivity, expected port, grant and read data.
    always @(negedge clk) begin
        exp_t       e;
        int         got;
        logic [7:0] rd;
        if (!rst && (bus.ack0 || bus.ack1)) begin
            got = bus.ack1 ? 1 : 0;
            n_checks++;
            if (bus.ack0 && bus.ack1) begin
                n_fail++;
                $display("FAIL ack_exclusive: ack0=%0b ack1=%0b, required only one", bus.ack0, bus.ack1);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: port %0d acked, required no ack", got);
            end else begin
                e = sb.pop_front();
                if (got !== e.port) begin
                    n_fail++;
                    $display("FAIL ack_port: got port %0d, required port %0d", got, e.port);
                end
                n_checks++;
                if (int'(bus.grant) !== e.port) begin
                    n_fail++;
                    $display("FAIL grant_at_ack: got %0d, required %0d", bus.grant, e.port);
                end
                if (!e.we) begin
                    rd = got ? bus.rdata1 : bus.rdata0;
                    n_checks++;
                    if (rd !== e.data) begin
                        n_fail++;
                        $display("FAIL rdata_at_ack: port %0d got %02h, required %02h", got, rd, e.data);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic access(input int p, input bit we, input logic [7:0] addr,
                          input logic [7:0] wd, input bit drop_early, input string tag);
        int         lat, k, we_cnt, re_cnt;
        bit         seen;
        logic [7:0] a_seen, d_seen, rd;
        exp_t       e;
        lat    = we ? 2 : 2 + RD_LAT;
        e.port = p;
        e.we   = we;
        e.data = ref_mem[addr];
        if (we) ref_mem[addr] = wd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (p == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
        end
        k = 0; seen = 1'b0; we_cnt = 0; re_cnt = 0; a_seen = '0; d_seen = '0;
        while (!seen && k < 20) begin
            @(posedge clk);
            k++;
            if (drop_early && k == 1) begin
                #1;
                if (p == 0) bus.req0 = 1'b0;
                else        bus.req1 = 1'b0;
            end
            @(negedge clk);
            if (bus.mem_we) begin we_cnt++; a_seen = bus.mem_addr; d_seen = bus.mem_in; end
            if (bus.mem_re) begin re_cnt++; a_seen = bus.mem_addr; end
            seen = (p == 0) ? bus.ack0 : bus.ack1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        n_checks++;
        if (!seen || k != lat) begin
            n_fail++;
            $display("FAIL %s latency: ack after %0d cycles (seen=%0b), required %0d", tag, k, seen, lat);
            if (!seen) sb.delete();
        end
        n_checks++;
        if (we_cnt != (we ? 1 : 0) || re_cnt != (we ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s strobes: we_cycles=%0d re_cycles=%0d, required %0d/%0d",
                     tag, we_cnt, re_cnt, we ? 1 : 0, we ? 0 : 1);
        end
        n_checks++;
        if (a_seen !== addr) begin
            n_fail++;
            $display("FAIL %s mem_addr: got %02h, required %02h", tag, a_seen, addr);
        end
        if (we) begin
            n_checks++;
            if (d_seen !== wd) begin
                n_fail++;
                $display("FAIL %s mem_in: got %02h, required %02h", tag, d_seen, wd);
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_after_ack: got %0b, required 0", tag, bus.busy);
        end
        if (!we) begin
            rd = (p == 1) ? bus.rdata1 : bus.rdata0;
            n_checks++;
            if (rd !== e.data) begin
                n_fail++;
                $display("FAIL %s rdata_hold: got %02h, required %02h", tag, rd, e.data);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.ack0, bus.ack1, bus.mem_we, bus.mem_re, bus.busy, bus.grant} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ack0/ack1/we/re/busy/grant=%06b, required 000000",
                     {bus.ack0, bus.ack1, bus.mem_we, bus.mem_re, bus.busy, bus.grant});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_in} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mem_bus: addr=%02h in=%02h, required 00/00", bus.mem_addr, bus.mem_in);
        end
        n_checks++;
        if ({bus.rdata0, bus.rdata1} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_rdata: rdata0=%02h rdata1=%02h, required 00/00", bus.rdata0, bus.rdata1);
        end
    endtask

    task automatic test_write();
        access(0, 1'b1, 8'h10, 8'hA5, 1'b0, "p0_write");
    endtask

    task automatic test_read();
        access(0, 1'b0, 8'h10, 8'h00, 1'b0, "p0_read");
    endtask

    task automatic test_cross_port();
        access(1, 1'b1, 8'hFF, 8'h3C, 1'b0, "p1_write");
        access(0, 1'b0, 8'hFF, 8'h00, 1'b0, "p0_read_ff");
        n_checks++;
        if (bus.rdata1 !== 8'h00) begin
            n_fail++;
            $display("FAIL rdata1_untouched: got %02h, required 00", bus.rdata1);
        end
    endtask

    task automatic test_drop_early();
        access(1, 1'b0, 8'h10, 8'h00, 1'b1, "p1_read_drop");
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        @(posedge clk);
        #1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        repeat ((RD_LAT > 0) ? 2 : 1) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.req0 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.ack0, bus.ack1, bus.mem_re, bus.mem_we, bus.busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL midrst_ctrl: ack0/ack1/re/we/busy=%05b, required 00000",
                     {bus.ack0, bus.ack1, bus.mem_re, bus.mem_we, bus.busy});
        end
        n_checks++;
        if (bus.rdata0 !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_rdata0: got %02h, required 00", bus.rdata0);
        end
        repeat (4) @(negedge clk);
        access(0, 1'b0, 8'h10, 8'h00, 1'b0, "p0_read_after_rst");
    endtask

    task automatic test_arbitration();
        exp_t e;
        int   acks, n1, cyc, exp_n1;
        do_reset();
`ifdef UP_MEM_ARB_RR_EN
        exp_n1 = 2;
        ref_mem[8'h21] = 8'h22;
`else
        exp_n1 = 0;
`endif
        ref_mem[8'h20] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            e.port = (exp_n1 != 0) ? (i % 2) : 0;
            e.we   = 1'b1;
            e.data = 8'h00;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h20; bus.wdata0 = 8'h11;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h21; bus.wdata1 = 8'h22;
        acks = 0; n1 = 0; cyc = 0;
        while (acks < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.ack0 || bus.ack1) begin
                acks++;
                if (bus.ack1) n1++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        n_checks++;
        if (acks != 4) begin
            n_fail++;
            $display("FAIL arb_acks: got %0d acks in %0d cycles, required 4", acks, cyc);
        end
        n_checks++;
        if (n1 != exp_n1) begin
            n_fail++;
            $display("FAIL arb_port1_share: port 1 acks %0d, required %0d", n1, exp_n1);
        end
        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL arb_scoreboard: %0d entries left, required 0", sb.size());
            sb.delete();
        end
        access(0, 1'b0, 8'h20, 8'h00, 1'b0, "p0_read_arb");
    endtask

    initial begin
        rst = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_cross_port();
        test_drop_early();
        test_reset_mid_access();
        test_arbitration();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
